// File: rtl/mul_share_pkg.sv
// ---------------------------------------------------------------------------
// mul_share_pkg
// Shared constants and types for the shared 4x4 multiplier arbiter.
//   OPW         : operand width (bits per multiplicand / multiplier)
//   PW          : product width (full, untruncated)
//   out_state_e : output register state, EMPTY (no product) / FULL (product
//                 waiting for the consumer)
// ---------------------------------------------------------------------------
package mul_share_pkg;

    localparam int OPW = 4;
    localparam int PW  = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/mul4x4_core.sv
// ---------------------------------------------------------------------------
// mul4x4_core
// Purely combinational unsigned multiplier, OPW x OPW -> PW bits.
// Ports:
//   a : input  [OPW-1:0]  multiplicand
//   b : input  [OPW-1:0]  multiplier
//   p : output [PW-1:0]   full-width product a*b
// ---------------------------------------------------------------------------
module mul4x4_core
    import mul_share_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [PW-1:0]  p
);

    // Operands are widened first so the product is never truncated.
    assign p = PW'(a) * PW'(b);

endmodule

// File: rtl/mul_share_arb.sv
// ---------------------------------------------------------------------------
// mul_share_arb
// NREQ requesters share one combinational 4x4 multiplier. A round-robin
// arbiter picks one valid requester per cycle, its operands are muxed into
// the multiplier, and the product lands in a one-entry output register one
// cycle later. A new operation can be accepted in the same cycle the held
// product is drained, giving one operation per cycle back to back.
//
// Optional feature (macro MUL_OPCNT_EN): adds a 16-bit wrapping op_count
// output counting accepted operations.
//
// Ports:
//   clk        : input             clock, rising edge
//   rst        : input             synchronous active-high reset
//   req_valid  : input  [NREQ]     per-requester request valid
//   req_m      : input  [NREQ*4]   multiplicands, requester i at [4i+3:4i]
//   req_q      : input  [NREQ*4]   multipliers, same packing
//   req_ready  : output [NREQ]     one-hot (or zero) accept strobe
//   resp_valid : output            output register holds a product
//   resp_ready : input             consumer takes the product
//   resp_p     : output [8]        product
//   resp_id    : output [IDW]      requester index that issued resp_p
//   op_count   : output [16]       accepted operations (MUL_OPCNT_EN only)
// ---------------------------------------------------------------------------
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*OPW-1:0] req_m,
    input  logic [NREQ*OPW-1:0] req_q,
    output logic [NREQ-1:0]     req_ready,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [PW-1:0]       resp_p,
    output logic [IDW-1:0]      resp_id
`ifdef MUL_OPCNT_EN
    ,
    output logic [15:0]         op_count
`endif
);

    out_state_e     state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]  resp_p_q, resp_p_d;
    logic [IDW-1:0] resp_id_q, resp_id_d;

    logic           grant_any;
    logic [IDW-1:0] grant_idx;
    logic           can_accept;
    logic           xfer;
    logic [OPW-1:0] mux_m;
    logic [OPW-1:0] mux_q;
    logic [PW-1:0]  prod;

    // Round-robin search. Walking the offsets from highest to lowest lets the
    // smallest offset from rr_ptr (the highest-priority valid requester)
    // overwrite any earlier candidate.
    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
    end

    // rst gates the transfer so nothing is accepted in a reset cycle.
    assign can_accept = (state_q == EMPTY) | resp_ready;
    assign xfer       = grant_any & can_accept & ~rst;
    assign req_ready  = xfer ? (NREQ'(1) << grant_idx) : '0;

    assign mux_m = req_m[grant_idx*OPW +: OPW];
    assign mux_q = req_q[grant_idx*OPW +: OPW];

    mul4x4_core u_core (
        .a (mux_m),
        .b (mux_q),
        .p (prod)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        resp_p_d  = resp_p_q;
        resp_id_d = resp_id_q;
        if (xfer) begin
            state_d   = FULL;
            resp_p_d  = prod;
            resp_id_d = grant_idx;
            rr_ptr_d  = IDW'((int'(grant_idx) + 1) % NREQ);
        end else if (state_q == FULL && resp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            rr_ptr_q  <= '0;
            resp_p_q  <= '0;
            resp_id_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            resp_p_q  <= resp_p_d;
            resp_id_q <= resp_id_d;
        end
    end

    assign resp_valid = (state_q == FULL);
    assign resp_p     = resp_p_q;
    assign resp_id    = resp_id_q;

`ifdef MUL_OPCNT_EN
    logic [15:0] op_count_q, op_count_d;

    // 16-bit natural wrap from 65535 to 0.
    always_comb begin
        op_count_d = op_count_q;
        if (xfer) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: doc/mul_share_arb.md
MUL_SHARE_ARB -- requirements
Module: mul_share_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the multiplier; legal values 2..8.
REQ-002 Parameter IDW, default 2: requester-ID width; SHALL equal clog2(NREQ) and be at least 1.
REQ-003 clk  input  1  Single clock; all state changes on its rising edge.
REQ-004 rst  input  1  Synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  Per-requester request valid.
REQ-006 req_m  input  NREQ*4  Per-requester multiplicand; requester i uses bits [4i+3:4i].
REQ-007 req_q  input  NREQ*4  Per-requester multiplier; same packing as req_m.
REQ-008 req_ready  output  NREQ  One-hot or zero accept strobe per requester.
REQ-009 resp_valid  output  1  Result register holds an unconsumed product.
REQ-010 resp_ready  input  1  Consumer accepts the product.
REQ-011 resp_p  output  8  Unsigned product m*q.
REQ-012 resp_id  output  IDW  Index of the requester that issued the product.
REQ-013 op_count  output  16  Number of accepted operations; present only with MUL_OPCNT_EN.

Function
REQ-014 Arbitration SHALL be round-robin: search starts at pointer rr_ptr and proceeds upward modulo NREQ; the first requester with req_valid set wins.
REQ-015 can_accept SHALL be (!resp_valid) | resp_ready.
REQ-016 req_ready[i] SHALL be 1 only for the winner and only while can_accept is 1; it is combinational from req_valid, rr_ptr, resp_valid and resp_ready.
REQ-017 A transfer SHALL occur when req_valid[i] & req_ready[i] in a cycle.
REQ-018 On a transfer, the next edge SHALL load resp_p = m_i*q_i (full 8-bit, no truncation) and resp_id = i, and SHALL set resp_valid = 1.
REQ-019 Latency from transfer to resp_valid SHALL be exactly 1 cycle.
REQ-020 On a transfer, rr_ptr SHALL become (i+1) mod NREQ; with no transfer, rr_ptr SHALL hold.
REQ-021 Output stage states: EMPTY (resp_valid=0) and FULL (resp_valid=1).
- EMPTY -> FULL on transfer.
- FULL -> EMPTY on resp_ready with no transfer.
- FULL -> FULL (new data) on resp_ready with a simultaneous transfer, giving back-to-back throughput of 1 op/cycle.
- FULL with resp_ready=0: hold resp_p, resp_id and resp_valid stable, and drive req_ready to all zero.
REQ-022 Requesters may deassert req_valid without a transfer; the arbiter SHALL NOT record pending grants.
REQ-023 With no req_valid bit set, req_ready SHALL be all zero and no state other than draining SHALL change.
REQ-024 Operands 0 and 15 SHALL be handled without special cases (0*x=0, 15*15=225).

Reset
REQ-025 While rst=1 at an edge: resp_valid=0, resp_p=0, resp_id=0, rr_ptr=0, and op_count=0 when present.
REQ-026 Reset mid-operation SHALL discard any held product without issuing a response.
REQ-027 req_ready SHALL be all zero during any cycle in which rst=1.

Configuration
REQ-028 Macro MUL_OPCNT_EN defined: op_count port exists and increments by 1 per transfer, wrapping from 65535 to 0.
REQ-029 Macro MUL_OPCNT_EN absent: neither the op_count port nor the counter logic exist; all other behaviour is identical.

Structure
REQ-030 Shared package mul_share_pkg SHALL hold the operand width constant (4), the product width constant (8), and the output-state enum {EMPTY, FULL}.
REQ-031 The combinational multiplier SHALL be a sub-module mul4x4_core (a, b -> p); it is instantiated once and its inputs are muxed by the granted index.
REQ-032 The arbiter, mux and output register SHALL reside in mul_share_arb; there are no other sub-modules.

Verification
REQ-033 Reset, then req_valid=4'b0001, m0=3, q0=5, resp_ready=1 -> req_ready=4'b0001; next cycle resp_valid=1, resp_p=15, resp_id=0.
REQ-034 All four requesters valid continuously, resp_ready=1 -> grants 0,1,2,3,0,... one per cycle; resp_id follows the same order with 1-cycle lag.
REQ-035 Requester 2 only, m=15, q=15, resp_ready=0 for 3 cycles -> resp_p=225 stays stable, req_ready=0 throughout; on resp_ready=1 a new transfer is accepted in the same cycle.
REQ-036 rst asserted the cycle after a transfer with resp_ready=0 -> resp_valid=0, rr_ptr=0; after reset, requesters 1 and 3 valid -> requester 1 granted first.
REQ-037 With MUL_OPCNT_EN and op_count preloaded by 65535 transfers -> one more transfer yields op_count=0; with the macro absent, the build elaborates without the op_count port.
REQ-038 Exhaustive check on requester 0, all 256 (m,q) pairs -> resp_p equals m*q for every pair.
